// File: rtl/fifo_rd_streamer.sv
// rtl/fifo_rd_streamer.sv - async_fifo read-side streamer with skid buffer; FIFO_RD_STREAMER_ERR_EN adds err_sticky
module fifo_rd_streamer #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = RD_LATENCY + 1
) (
    input  logic                              rd_clock,
    input  logic                              reset,
    input  logic                              fifo_empty,
    input  logic                              fifo_valid,
    input  logic [DATA_WIDTH-1:0]             fifo_dout,
    output logic                              fifo_rd_en,
    input  logic                              flush,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   buf_level
`ifdef FIFO_RD_STREAMER_ERR_EN
    ,
    output logic                              err_sticky
`endif
);

    localparam int LW = $clog2(SKID_DEPTH + 1);
    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int IW = $clog2(RD_LATENCY + 1);

    logic [DATA_WIDTH-1:0] buf_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] buf_d [SKID_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [IW-1:0]         inflight_q, inflight_d;
    logic [IW-1:0]         discard_q, discard_d;

    logic                  pop;
    logic                  rd_en;
    logic                  beat_ret;
    logic                  capture;
    logic [7:0]            occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign m_valid    = (level_q != '0);
    assign m_data     = buf_q[rd_ptr_q];
    assign buf_level  = level_q;
    assign fifo_rd_en = rd_en;

    // Issue/return decode: a slot is reserved for every outstanding read, so a returning beat always fits
    always_comb begin
        pop      = (level_q != '0) && m_ready;
        occ      = 8'(level_q) + 8'(inflight_q) - 8'(pop);
        rd_en    = !reset && !fifo_empty && !flush && (occ < 8'(SKID_DEPTH));
        // A beat with nothing outstanding is a stray and is ignored entirely
        beat_ret = fifo_valid && (inflight_q != '0);
        capture  = beat_ret && (discard_q == '0) && !flush;
    end

    // Next-state for the circular buffer, pointers and the in-flight/discard counters
    always_comb begin
        buf_d      = buf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;

        if (rd_en && !beat_ret) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!rd_en && beat_ret) begin
            inflight_d = inflight_q - IW'(1);
        end

        if (flush) begin
            // Everything still outstanding after this cycle must be thrown away on return
            level_d   = '0;
            rd_ptr_d  = wr_ptr_q;
            discard_d = inflight_d;
        end else begin
            if (capture) begin
                buf_d[wr_ptr_q] = fifo_dout;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (beat_ret && (discard_q != '0)) begin
                discard_d = discard_q - IW'(1);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (capture && !pop) begin
                level_d = level_q + LW'(1);
            end else if (!capture && pop) begin
                level_d = level_q - LW'(1);
            end
        end
    end

    // State registers, cleared asynchronously so outputs drop to zero immediately
    always_ff @(posedge rd_clock or posedge reset) begin
        if (reset) begin
            buf_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            buf_q      <= buf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

`ifdef FIFO_RD_STREAMER_ERR_EN
    logic err_event;
    logic err_sticky_q, err_sticky_d;

    assign err_sticky = err_sticky_q;

    // Protocol violations: stray return beat, or a read issued against an empty FIFO
    always_comb begin
        err_event    = (fifo_valid && (inflight_q == '0) && (discard_q == '0)) ||
                       (rd_en && fifo_empty);
        err_sticky_d = err_sticky_q || err_event;
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge rd_clock or posedge reset) begin
        if (reset) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    // Simulation-time report of the same violations
    always @(posedge rd_clock) begin
        if (!reset) begin
            assert (!err_event) else $error("fifo_rd_streamer: read protocol violation");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb/tb_fifo_rd_streamer.sv - self-checking bench for fifo_rd_streamer with queue-based FIFO and stream model
module tb_fifo_rd_streamer;

    localparam int DW = 64;
    localparam int SD = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty;
    logic          fifo_valid;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    buf_level;
`ifdef FIFO_RD_STREAMER_ERR_EN
    logic          err_sticky;
`endif

    always #5 clk = ~clk;

    fifo_rd_streamer #(.DATA_WIDTH(DW), .RD_LATENCY(1), .SKID_DEPTH(SD)) dut (
        .rd_clock   (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_valid (fifo_valid),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .buf_level  (buf_level)
`ifdef FIFO_RD_STREAMER_ERR_EN
        ,
        .err_sticky (err_sticky)
`endif
    );

    logic [DW-1:0] fq[$];     // words still inside the FIFO
    logic [DW-1:0] exp_q[$];  // words read from the FIFO, not yet delivered or dropped
    int            n_checks = 0;
    int            n_err    = 0;
    bit            hs;
    bit            flush_prev = 1'b0;
    logic [DW-1:0] last_data;
    int            rd_cnt;
    int            delivered, first, gaps;
    logic [DW-1:0] head;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_checks++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    // One clock cycle: check outputs before the edge, then model the FIFO read port after it
    task automatic cyc();
        logic          rd;
        logic [DW-1:0] want;
        fifo_empty = (fq.size() == 0);
        #1;
        hs = m_valid && m_ready;
        rd = fifo_rd_en;
        if (flush_prev) chk("flush_clears_valid", DW'(m_valid), DW'(0));
        if (m_valid) chk("valid_has_data", DW'(exp_q.size() != 0), DW'(1));
        if (hs && exp_q.size() != 0) begin
            want = exp_q.pop_front();
            chk("m_data", m_data, want);
            last_data = m_data;
        end
        if (rd) chk("rd_when_empty", DW'(fifo_empty), DW'(0));
        if (flush) begin
            chk("rd_during_flush", DW'(rd), DW'(0));
            exp_q.delete();
        end
        chk("buf_level_max", DW'(buf_level <= 2'(SD)), DW'(1));
        if (rd) rd_cnt++;
        flush_prev = flush;
        @(posedge clk);
        #1;
        if (rd && fq.size() != 0) begin
            fifo_dout  = fq.pop_front();
            fifo_valid = 1'b1;
            exp_q.push_back(fifo_dout);
        end else begin
            fifo_valid = 1'b0;
            fifo_dout  = DW'($urandom);
        end
        fifo_empty = (fq.size() == 0);
    endtask

    // Run with m_ready held high until everything is delivered; counts gaps after the first beat
    task automatic drain(input string tag, input int budget);
        delivered = 0;
        first     = -1;
        gaps      = 0;
        for (int c = 0; c < budget && (fq.size() != 0 || exp_q.size() != 0); c++) begin
            cyc();
            if (hs) begin
                if (first < 0) first = c;
                delivered++;
            end else if (first >= 0 && (fq.size() != 0 || exp_q.size() != 0)) begin
                gaps++;
            end
        end
        chk({tag, "_drained"}, DW'(fq.size() + exp_q.size()), DW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        fifo_empty = 1'b0;
        fifo_valid = 1'b0;
        fifo_dout  = '0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en", DW'(fifo_rd_en), DW'(0));
        chk("rst_m_valid", DW'(m_valid), DW'(0));
        chk("rst_m_data", m_data, DW'(0));
        chk("rst_level", DW'(buf_level), DW'(0));
        reset = 1'b0;

        // Streaming 0..99
        for (int i = 0; i < 100; i++) fq.push_back(DW'(i));
        m_ready = 1'b1;
        drain("stream", 300);
        chk("stream_count", DW'(delivered), DW'(100));
        chk("stream_latency", DW'(first), DW'(2));
        chk("stream_gaps", DW'(gaps), DW'(0));

        // Backpressure: 8 beats, m_ready low for 20 cycles
        for (int i = 0; i < 8; i++) fq.push_back(DW'(i));
        m_ready = 1'b0;
        rd_cnt  = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (c >= 2) chk("bp_hold", {m_data[DW-2:0], m_valid}, DW'(1));
        end
        chk("bp_reads", DW'(rd_cnt), DW'(SD));
        m_ready = 1'b1;
        drain("bp", 100);
        chk("bp_count", DW'(delivered), DW'(8));
        chk("bp_first", DW'(first), DW'(0));
        chk("bp_gaps", DW'(gaps), DW'(0));

        // Empty boundary: a single word
        fq.push_back(DW'(8'h5A));
        rd_cnt    = 0;
        delivered = 0;
        last_data = '0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (hs) delivered++;
        end
        chk("one_word_reads", DW'(rd_cnt), DW'(1));
        chk("one_word_count", DW'(delivered), DW'(1));
        chk("one_word_data", last_data, DW'(8'h5A));
        chk("empty_no_rd", DW'(fifo_rd_en), DW'(0));

        // Flush with one beat buffered and one read returning
        for (int i = 10; i < 16; i++) fq.push_back(DW'(i));
        m_ready = 1'b0;
        repeat (4) cyc();
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        flush   = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_level", DW'(buf_level), DW'(0));
        chk("flush_valid", DW'(m_valid), DW'(0));
        m_ready = 1'b1;
        hs      = 1'b0;
        for (int c = 0; c < 10 && !hs; c++) cyc();
        chk("flush_next_beat", last_data, DW'(13));
        drain("flush", 50);

        // Reset while beat 40 is presented
        for (int i = 20; i < 60; i++) fq.push_back(DW'(i));
        m_ready = 1'b1;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                cyc();
                seen = m_valid && (m_data == DW'(40));
            end
            chk("rst_reach_40", DW'(seen), DW'(1));
        end
        #2;
        reset      = 1'b1;
        fifo_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_m_valid", DW'(m_valid), DW'(0));
        chk("arst_m_data", m_data, DW'(0));
        chk("arst_level", DW'(buf_level), DW'(0));
        chk("arst_rd_en", DW'(fifo_rd_en), DW'(0));
        @(posedge clk);
        #1;
        cyc();
        cyc();
        reset = 1'b0;
        head  = fq[0];
        hs    = 1'b0;
        for (int c = 0; c < 10 && !hs; c++) cyc();
        chk("rst_resume_head", last_data, head);
        drain("rst", 100);

`ifdef FIFO_RD_STREAMER_ERR_EN
        chk("err_idle", DW'(err_sticky), DW'(0));
        fifo_valid = 1'b1;
        cyc();
        chk("err_set", DW'(err_sticky), DW'(1));
        repeat (3) cyc();
        chk("err_stays", DW'(err_sticky), DW'(1));
        chk("err_beat_dropped", DW'(m_valid), DW'(0));
`endif

        // Randomized traffic, backpressure and flushes against the stream model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(1, 0) == 1) fq.push_back({$urandom, $urandom});
            flush   = ($urandom_range(29, 0) == 0);
            m_ready = flush ? 1'b0 : 1'($urandom_range(1, 0));
            cyc();
        end
        flush   = 1'b0;
        m_ready = 1'b1;
        drain("rand", 600);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
